// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings and default frame settings.
// Used by spi_slave and by the SPI master in the peripherals block.
package spi_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;

    // Default frame width and the word shifted out when nothing is pending
    localparam int         SPI_WIDTH   = 8;
    localparam logic [7:0] SPI_IDLE_TX = 8'hff;

endpackage

// File: rtl/spi_sync_edge.sv
// Pin synchronizer with edge detection.
// SYNC_STAGES flops (at least 2) bring an asynchronous pin into the clk
// domain; one extra history flop yields single-cycle rise/fall pulses.
// RESET_VAL is the pin's idle level, so releasing reset creates no edge.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the pin through the synchronizer chain and keep one cycle of history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            hist_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, mode 0, MSB first, oversampled in the clk domain.
// Optional build macro SPI_SLAVE_OVERRUN_EN adds a sticky rx_overrun flag.
//
// Handshakes:
//   transmit: tx_ready=1 means the holding register is empty; a tx_load
//     cycle with tx_ready=1 captures tx_data, and tx_load with tx_ready=0
//     is ignored. If the shifter reloads in the same cycle as a load into
//     an empty register, tx_data goes straight to the shifter.
//   receive: rx_valid=1 means rx_data holds an unread word; rx_ack clears
//     it next cycle unless a new word completes in that same cycle.
module spi_slave
    import spi_pkg::*;
#(
    parameter int               WIDTH       = SPI_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_TX     = WIDTH'(SPI_IDLE_TX),
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs_n,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ack,
    output logic             busy
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    output logic             rx_overrun
`endif
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic             cs_level, cs_rise, cs_fall;
    logic             sclk_level, sclk_rise, sclk_fall;
    logic             mosi_level, mosi_rise, mosi_fall;
    logic             unused_sync;

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] hold_data;
    logic             hold_full;

    logic             start;
    logic             word_done;
    logic             reload;
    logic [WIDTH-1:0] reload_word;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .pin(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .pin(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .pin(mosi),
        .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only the edges of cs_n/sclk and the level of mosi are used
    assign unused_sync = &{1'b0, cs_level, sclk_level, mosi_rise, mosi_fall};

    // Frame start, word completion and the word the shifter reloads with
    always_comb begin
        start       = (state == ST_IDLE) && cs_fall;
        word_done   = (state == ST_SHIFT) && !cs_rise && sclk_rise && (bit_cnt == LAST_BIT);
        reload      = start || word_done;
        reload_word = IDLE_TX;
        if (hold_full) begin
            reload_word = hold_data;
        end else if (tx_load) begin
            reload_word = tx_data;
        end
    end

    // Frame FSM: cs_n rise aborts from any state; sclk is ignored in IDLE,
    // which also drops an sclk edge coinciding with the cs_n fall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= IDLE_TX;
            miso_oe  <= 1'b0;
            busy     <= 1'b0;
        end else if (cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            miso_oe <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        tx_shift <= reload_word;
                        bit_cnt  <= '0;
                        miso_oe  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift <= {rx_shift[WIDTH-2:0], mosi_level};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt  <= '0;
                            tx_shift <= reload_word;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall && (bit_cnt != '0)) begin
                        // The fall right after a word boundary keeps the
                        // freshly loaded MSB on miso
                        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Receive register: a completing word wins over a same-cycle rx_ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (word_done) begin
            rx_data  <= {rx_shift[WIDTH-2:0], mosi_level};
            rx_valid <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

    // Transmit holding register; survives a cs_n abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (reload && hold_full) begin
            hold_full <= 1'b0;
        end else if (tx_load && !hold_full && !reload) begin
            hold_data <= tx_data;
            hold_full <= 1'b1;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    // Sticky overrun: a word lands on an unread, unacknowledged one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_overrun <= 1'b0;
        end else if (rx_ack) begin
            rx_overrun <= 1'b0;
        end else if (word_done && rx_valid) begin
            rx_overrun <= 1'b1;
        end
    end
`endif

    assign miso     = tx_shift[WIDTH-1];
    assign tx_ready = !hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model driving the pins at
// clk/8, with hand-computed expected words for each scenario.
module tb_spi_slave;

    logic       clk;
    logic       reset;
    logic       cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       rx_overrun;
`endif

    int checks_total;
    int checks_passed;
    logic [7:0] got;
    logic [7:0] got2;

    spi_slave dut (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ack   (rx_ack),
        .busy     (busy)
`ifdef SPI_SLAVE_OVERRUN_EN
        ,
        .rx_overrun (rx_overrun)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic cs_select();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_release();
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [7:0] val);
        @(negedge clk);
        tx_data = val;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    // Mode-0 master: mosi set while sclk low, miso sampled at the rise.
    // Half period is 4 clk; load_bit >= 0 pulses tx_load during that bit.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input int load_bit,
                            input logic [7:0] load_val, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            if (i == load_bit) begin
                pulse_load(load_val);
                repeat (2) @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
            sclk = 1'b1;
            mi = {mi[6:0], miso};
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks_total++; if (miso !== 1'b1) $display("FAIL reset_miso got %b exp 1", miso); else checks_passed++;
        checks_total++; if (miso_oe !== 1'b0) $display("FAIL reset_miso_oe got %b exp 0", miso_oe); else checks_passed++;
        checks_total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b exp 1", tx_ready); else checks_passed++;
        checks_total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data); else checks_passed++;
        checks_total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b exp 0", rx_valid); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else checks_passed++;
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        cs_select();
        checks_total++; if (busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy); else checks_passed++;
        checks_total++; if (miso_oe !== 1'b1) $display("FAIL basic_oe got %b exp 1", miso_oe); else checks_passed++;
        spi_xfer(8'ha5, 8, -1, 8'h00, got);
        checks_total++; if (got !== 8'hff) $display("FAIL basic_master_rx got %h exp ff", got); else checks_passed++;
        checks_total++; if (rx_valid !== 1'b1) $display("FAIL basic_rx_valid got %b exp 1", rx_valid); else checks_passed++;
        checks_total++; if (rx_data !== 8'ha5) $display("FAIL basic_rx_data got %h exp a5", rx_data); else checks_passed++;
        cs_release();
        checks_total++; if (miso_oe !== 1'b0) $display("FAIL basic_oe_off got %b exp 0", miso_oe); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL basic_busy_off got %b exp 0", busy); else checks_passed++;
        pulse_ack();
        checks_total++; if (rx_valid !== 1'b0) $display("FAIL basic_ack got %b exp 0", rx_valid); else checks_passed++;
    endtask

    task automatic test_tx_load();
        pulse_load(8'h3c);
        @(negedge clk);
        checks_total++; if (tx_ready !== 1'b0) $display("FAIL load_tx_ready_low got %b exp 0", tx_ready); else checks_passed++;
        cs_select();
        checks_total++; if (tx_ready !== 1'b1) $display("FAIL load_tx_ready_back got %b exp 1", tx_ready); else checks_passed++;
        spi_xfer(8'h00, 8, -1, 8'h00, got);
        checks_total++; if (got !== 8'h3c) $display("FAIL load_master_rx got %h exp 3c", got); else checks_passed++;
        checks_total++; if (rx_data !== 8'h00) $display("FAIL load_rx_data got %h exp 00", rx_data); else checks_passed++;
        cs_release();
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        cs_select();
        spi_xfer(8'h12, 8, 3, 8'hc3, got);
        checks_total++; if (got !== 8'hff) $display("FAIL b2b_master_rx1 got %h exp ff", got); else checks_passed++;
        checks_total++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid1 got %b exp 1", rx_valid); else checks_passed++;
        checks_total++; if (rx_data !== 8'h12) $display("FAIL b2b_rx_data1 got %h exp 12", rx_data); else checks_passed++;
        checks_total++; if (tx_ready !== 1'b1) $display("FAIL b2b_tx_ready got %b exp 1", tx_ready); else checks_passed++;
        pulse_ack();
        checks_total++; if (rx_valid !== 1'b0) $display("FAIL b2b_ack1 got %b exp 0", rx_valid); else checks_passed++;
        spi_xfer(8'h34, 8, -1, 8'h00, got);
        checks_total++; if (got !== 8'hc3) $display("FAIL b2b_master_rx2 got %h exp c3", got); else checks_passed++;
        checks_total++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid2 got %b exp 1", rx_valid); else checks_passed++;
        checks_total++; if (rx_data !== 8'h34) $display("FAIL b2b_rx_data2 got %h exp 34", rx_data); else checks_passed++;
        cs_release();
        pulse_ack();
    endtask

    task automatic test_abort();
        cs_select();
        spi_xfer(8'hf0, 5, -1, 8'h00, got);
        cs_release();
        checks_total++; if (rx_valid !== 1'b0) $display("FAIL abort_valid got %b exp 0", rx_valid); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else checks_passed++;
        cs_select();
        spi_xfer(8'h81, 8, -1, 8'h00, got);
        checks_total++; if (rx_data !== 8'h81) $display("FAIL abort_next_rx got %h exp 81", rx_data); else checks_passed++;
        checks_total++; if (got !== 8'hff) $display("FAIL abort_master_rx got %h exp ff", got); else checks_passed++;
        cs_release();
        pulse_ack();
    endtask

    task automatic test_overwrite();
        cs_select();
        spi_xfer(8'h11, 8, -1, 8'h00, got);
        spi_xfer(8'h22, 8, -1, 8'h00, got2);
        checks_total++; if (rx_data !== 8'h22) $display("FAIL ovw_rx_data got %h exp 22", rx_data); else checks_passed++;
        checks_total++; if (rx_valid !== 1'b1) $display("FAIL ovw_valid got %b exp 1", rx_valid); else checks_passed++;
`ifdef SPI_SLAVE_OVERRUN_EN
        checks_total++; if (rx_overrun !== 1'b1) $display("FAIL ovw_overrun_set got %b exp 1", rx_overrun); else checks_passed++;
`endif
        cs_release();
        pulse_ack();
        checks_total++; if (rx_valid !== 1'b0) $display("FAIL ovw_ack got %b exp 0", rx_valid); else checks_passed++;
`ifdef SPI_SLAVE_OVERRUN_EN
        checks_total++; if (rx_overrun !== 1'b0) $display("FAIL ovw_overrun_clr got %b exp 0", rx_overrun); else checks_passed++;
`endif
    endtask

    task automatic test_reset_mid_frame();
        cs_select();
        spi_xfer(8'h99, 8, -1, 8'h00, got);
        pulse_load(8'h77);
        @(negedge clk);
        checks_total++; if (tx_ready !== 1'b0) $display("FAIL rmid_pre_tx_ready got %b exp 0", tx_ready); else checks_passed++;
        spi_xfer(8'hff, 4, -1, 8'h00, got);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks_total++; if (miso !== 1'b1) $display("FAIL rmid_miso got %b exp 1", miso); else checks_passed++;
        checks_total++; if (miso_oe !== 1'b0) $display("FAIL rmid_oe got %b exp 0", miso_oe); else checks_passed++;
        checks_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b exp 0", busy); else checks_passed++;
        checks_total++; if (tx_ready !== 1'b1) $display("FAIL rmid_tx_ready got %b exp 1", tx_ready); else checks_passed++;
        checks_total++; if (rx_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", rx_valid); else checks_passed++;
        checks_total++; if (rx_data !== 8'h00) $display("FAIL rmid_rx_data got %h exp 00", rx_data); else checks_passed++;
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        cs_select();
        spi_xfer(8'h5a, 8, -1, 8'h00, got);
        checks_total++; if (rx_data !== 8'h5a) $display("FAIL rmid_next_rx got %h exp 5a", rx_data); else checks_passed++;
        checks_total++; if (rx_valid !== 1'b1) $display("FAIL rmid_next_valid got %b exp 1", rx_valid); else checks_passed++;
        checks_total++; if (got !== 8'hff) $display("FAIL rmid_master_rx got %h exp ff", got); else checks_passed++;
        cs_release();
        pulse_ack();
    endtask

    // Sequence and report
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset   = 1'b1;
        cs_n    = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        tx_data = 8'h00;
        tx_load = 1'b0;
        rx_ack  = 1'b0;
        test_reset();
        test_basic();
        test_tx_load();
        test_back_to_back();
        test_abort();
        test_overwrite();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
